// File: rtl/lbm_fixed_divider.sv
// lbm_fixed_divider: sequential signed fixed-point divider for the LBM velocity step.
// Restoring division, one quotient bit per clock, with sign fix-up and saturation.
//
// Ports:
//   Clk          system clock, rising edge
//   Reset        asynchronous active-high reset
//   div_start    request, sampled only while idle
//   dividend     signed numerator (momentum), Q(DATA_WIDTH-FRAC_BITS).FRAC_BITS
//   divisor      signed denominator (density), same format
//   quotient     signed result, held until the next completion
//   div_valid    one-cycle registered pulse when quotient is updated
//   div_busy     high whenever a division is in progress
//   div_by_zero  status of the last completed division: divisor was zero
//   div_ovf      status of the last completed division: result saturated
//
// Build option: define LBM_DIV_ROUND_EN to round half-up using one extra guard
// iteration; otherwise the result is truncated toward zero.

module lbm_fixed_divider #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned FRAC_BITS  = 16
) (
    input  logic                  Clk,
    input  logic                  Reset,
    input  logic                  div_start,
    input  logic [DATA_WIDTH-1:0] dividend,
    input  logic [DATA_WIDTH-1:0] divisor,
    output logic [DATA_WIDTH-1:0] quotient,
    output logic                  div_valid,
    output logic                  div_busy,
    output logic                  div_by_zero,
    output logic                  div_ovf
);

`ifdef LBM_DIV_ROUND_EN
    localparam int unsigned NIter = DATA_WIDTH + FRAC_BITS + 1;
`else
    localparam int unsigned NIter = DATA_WIDTH + FRAC_BITS;
`endif
    // The numerator register doubles as the quotient register: each iteration
    // shifts one numerator bit out of the top and one quotient bit in at the bottom.
    localparam int unsigned NumW      = NIter;
    localparam int unsigned CntW      = $clog2(NIter + 1);
    localparam int unsigned LoadShift = NIter - DATA_WIDTH;

    localparam logic [CntW-1:0]       LastCnt = CntW'(NIter - 1);
    localparam logic [NumW-1:0]       MaxPos  = NumW'({(DATA_WIDTH-1){1'b1}});
    localparam logic [NumW-1:0]       MaxNeg  = MaxPos + NumW'(1);
    localparam logic [DATA_WIDTH-1:0] SatPos  = {1'b0, {(DATA_WIDTH-1){1'b1}}};
    localparam logic [DATA_WIDTH-1:0] SatNeg  = {1'b1, {(DATA_WIDTH-1){1'b0}}};

    typedef enum logic [1:0] {
        StIdle,
        StCalc,
        StFix
    } state_e;

    state_e                state_q, state_d;
    logic [CntW-1:0]       cnt_q, cnt_d;
    logic [NumW-1:0]       num_q, num_d;
    logic [DATA_WIDTH-1:0] rem_q, rem_d;
    logic [DATA_WIDTH:0]   dvs_q, dvs_d;
    logic                  neg_q, neg_d;
    logic                  a_neg_q, a_neg_d;
    logic                  zero_q, zero_d;
    logic [DATA_WIDTH-1:0] quo_q, quo_d;
    logic                  valid_q, valid_d;
    logic                  dbz_q, dbz_d;
    logic                  ovf_q, ovf_d;

    // Operand magnitudes carry one extra bit so -2^(DATA_WIDTH-1) stays exact.
    logic [DATA_WIDTH:0]   ext_a, ext_b, mag_a, mag_b;
    logic [DATA_WIDTH:0]   rem_sh;
    logic [DATA_WIDTH-1:0] rem_sub;
    logic                  ge;
    logic [NumW-1:0]       mag;
    logic [DATA_WIDTH-1:0] neg_res;

    always_comb begin
        ext_a = {dividend[DATA_WIDTH-1], dividend};
        ext_b = {divisor[DATA_WIDTH-1], divisor};
        mag_a = dividend[DATA_WIDTH-1] ? -ext_a : ext_a;
        mag_b = divisor[DATA_WIDTH-1] ? -ext_b : ext_b;
    end

    // Partial remainder is always < divisor <= 2^(DATA_WIDTH-1), so the
    // subtraction result fits in DATA_WIDTH bits.
    always_comb begin
        rem_sh  = {rem_q, num_q[NumW-1]};
        ge      = (rem_sh >= dvs_q);
        rem_sub = DATA_WIDTH'(rem_sh - dvs_q);
    end

`ifdef LBM_DIV_ROUND_EN
    // LSB of num_q is the guard bit; adding it rounds the magnitude half-up.
    always_comb mag = {1'b0, num_q[NumW-1:1]} + NumW'(num_q[0]);
`else
    always_comb mag = num_q;
`endif

    always_comb neg_res = -mag[DATA_WIDTH-1:0];

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        num_d   = num_q;
        rem_d   = rem_q;
        dvs_d   = dvs_q;
        neg_d   = neg_q;
        a_neg_d = a_neg_q;
        zero_d  = zero_q;
        quo_d   = quo_q;
        valid_d = 1'b0;
        dbz_d   = dbz_q;
        ovf_d   = ovf_q;

        unique case (state_q)
            StIdle: begin
                if (div_start) begin
                    neg_d   = dividend[DATA_WIDTH-1] ^ divisor[DATA_WIDTH-1];
                    a_neg_d = dividend[DATA_WIDTH-1];
                    zero_d  = (divisor == '0);
                    num_d   = NumW'(mag_a) << LoadShift;
                    dvs_d   = mag_b;
                    rem_d   = '0;
                    cnt_d   = '0;
                    state_d = (divisor == '0) ? StFix : StCalc;
                end
            end
            StCalc: begin
                num_d = {num_q[NumW-2:0], ge};
                rem_d = ge ? rem_sub : rem_sh[DATA_WIDTH-1:0];
                cnt_d = cnt_q + CntW'(1);
                if (cnt_q == LastCnt) begin
                    state_d = StFix;
                end
            end
            StFix: begin
                valid_d = 1'b1;
                state_d = StIdle;
                if (zero_q) begin
                    quo_d = a_neg_q ? SatNeg : SatPos;
                    dbz_d = 1'b1;
                    ovf_d = 1'b0;
                end else begin
                    dbz_d = 1'b0;
                    if (neg_q) begin
                        ovf_d = (mag > MaxNeg);
                        quo_d = (mag > MaxNeg) ? SatNeg : neg_res;
                    end else begin
                        ovf_d = (mag > MaxPos);
                        quo_d = (mag > MaxPos) ? SatPos : mag[DATA_WIDTH-1:0];
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            num_q   <= '0;
            rem_q   <= '0;
            dvs_q   <= '0;
            neg_q   <= 1'b0;
            a_neg_q <= 1'b0;
            zero_q  <= 1'b0;
            quo_q   <= '0;
            valid_q <= 1'b0;
            dbz_q   <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            num_q   <= num_d;
            rem_q   <= rem_d;
            dvs_q   <= dvs_d;
            neg_q   <= neg_d;
            a_neg_q <= a_neg_d;
            zero_q  <= zero_d;
            quo_q   <= quo_d;
            valid_q <= valid_d;
            dbz_q   <= dbz_d;
            ovf_q   <= ovf_d;
        end
    end

    assign quotient    = quo_q;
    assign div_valid   = valid_q;
    assign div_busy    = (state_q != StIdle);
    assign div_by_zero = dbz_q;
    assign div_ovf     = ovf_q;

endmodule

// File: tb/tb_lbm_fixed_divider.sv
// Directed testbench for lbm_fixed_divider at default parameters (Q16.16).
module tb_lbm_fixed_divider;

    logic        Clk = 1'b0;
    logic        Reset;
    logic        div_start;
    logic [31:0] dividend;
    logic [31:0] divisor;
    logic [31:0] quotient;
    logic        div_valid;
    logic        div_busy;
    logic        div_by_zero;
    logic        div_ovf;

    int n_run  = 0;
    int n_fail = 0;

`ifdef LBM_DIV_ROUND_EN
    localparam int          Lat       = 50;
    localparam logic [31:0] TwoThirds = 32'h0000_AAAB;
`else
    localparam int          Lat       = 49;
    localparam logic [31:0] TwoThirds = 32'h0000_AAAA;
`endif

    lbm_fixed_divider dut (
        .Clk         (Clk),
        .Reset       (Reset),
        .div_start   (div_start),
        .dividend    (dividend),
        .divisor     (divisor),
        .quotient    (quotient),
        .div_valid   (div_valid),
        .div_busy    (div_busy),
        .div_by_zero (div_by_zero),
        .div_ovf     (div_ovf)
    );

    always #5 Clk = ~Clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_run++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Starts a division, then counts edges after the start edge until div_valid.
    // Returns with time just after the div_valid edge (inside the valid cycle).
    task automatic run_div(input logic [31:0] a, input logic [31:0] b, input bit hold,
                           output logic [31:0] q, output int lat, output int busy_n,
                           output bit stable);
        logic [31:0] q0;
        @(negedge Clk);
        dividend  = a;
        divisor   = b;
        div_start = 1'b1;
        q0        = quotient;
        @(posedge Clk);
        #1;
        if (!hold) div_start = 1'b0;
        dividend = 32'h1234_5678;
        divisor  = 32'h0000_0003;
        lat      = -1;
        busy_n   = 0;
        stable   = 1'b1;
        for (int i = 1; i <= 200; i++) begin
            if (div_busy) busy_n++;
            @(posedge Clk);
            #1;
            if (div_valid) begin
                lat = i;
                break;
            end
            if (quotient !== q0) stable = 1'b0;
        end
        div_start = 1'b0;
        q         = quotient;
    endtask

    logic [31:0] q;
    int          lat;
    int          busy_n;
    bit          stable;
    bit          seen;

    initial begin
        Reset     = 1'b1;
        div_start = 1'b0;
        dividend  = '0;
        divisor   = '0;
        repeat (2) @(posedge Clk);
        #1;
        chk("rst_quotient", quotient, 32'h0);
        chk("rst_valid", {31'b0, div_valid}, 32'h0);
        chk("rst_busy", {31'b0, div_busy}, 32'h0);
        chk("rst_flags", {30'b0, div_by_zero, div_ovf}, 32'h0);
        @(negedge Clk);
        Reset = 1'b0;

        // 1.0 / 2.0
        run_div(32'h0001_0000, 32'h0002_0000, 1'b0, q, lat, busy_n, stable);
        chk("basic_q", q, 32'h0000_8000);
        chk("basic_lat", 32'(lat), 32'(Lat));
        chk("basic_busy", 32'(busy_n), 32'(Lat));
        chk("basic_flags", {30'b0, div_by_zero, div_ovf}, 32'h0);
        @(posedge Clk);
        #1;
        chk("basic_pulse", {31'b0, div_valid}, 32'h0);

        // -3.0 / 2.0
        run_div(32'hFFFD_0000, 32'h0002_0000, 1'b0, q, lat, busy_n, stable);
        chk("neg_q", q, 32'hFFFE_8000);

        // 2.0 / 3.0
        run_div(32'h0002_0000, 32'h0003_0000, 1'b0, q, lat, busy_n, stable);
        chk("third_q", q, TwoThirds);
        chk("third_lat", 32'(lat), 32'(Lat));

        // Divide by zero, positive dividend
        run_div(32'h0005_0000, 32'h0000_0000, 1'b0, q, lat, busy_n, stable);
        chk("dbz_q", q, 32'h7FFF_FFFF);
        chk("dbz_lat", 32'(lat), 32'd1);
        chk("dbz_flags", {30'b0, div_by_zero, div_ovf}, 32'h2);

        // Reset in the middle of CALC
        @(negedge Clk);
        dividend  = 32'h0001_0000;
        divisor   = 32'h0002_0000;
        div_start = 1'b1;
        @(posedge Clk);
        #1;
        div_start = 1'b0;
        repeat (10) @(posedge Clk);
        #3;
        Reset = 1'b1;
        #1;
        chk("midrst_q", quotient, 32'h0);
        chk("midrst_busy", {31'b0, div_busy}, 32'h0);
        chk("midrst_flags", {30'b0, div_by_zero, div_ovf}, 32'h0);
        @(negedge Clk);
        Reset = 1'b0;
        seen  = 1'b0;
        repeat (60) begin
            @(posedge Clk);
            #1;
            if (div_valid) seen = 1'b1;
        end
        chk("midrst_novalid", {31'b0, seen}, 32'h0);
        run_div(32'h0001_0000, 32'h0002_0000, 1'b0, q, lat, busy_n, stable);
        chk("postrst_q", q, 32'h0000_8000);
        chk("postrst_lat", 32'(lat), 32'(Lat));

        // Divide by zero, negative dividend
        run_div(32'hFFFB_0000, 32'h0000_0000, 1'b0, q, lat, busy_n, stable);
        chk("dbzneg_q", q, 32'h8000_0000);

        // Positive overflow
        run_div(32'h7FFF_0000, 32'h0000_0001, 1'b0, q, lat, busy_n, stable);
        chk("ovf_q", q, 32'h7FFF_FFFF);
        chk("ovf_flags", {30'b0, div_by_zero, div_ovf}, 32'h1);

        // Most negative / smallest negative: huge positive, saturates
        run_div(32'h8000_0000, 32'hFFFF_FFFF, 1'b0, q, lat, busy_n, stable);
        chk("ovfmin_q", q, 32'h7FFF_FFFF);
        chk("ovfmin_flags", {30'b0, div_by_zero, div_ovf}, 32'h1);

        // -32768.0 / 1.0 is exactly representable: no saturation
        run_div(32'h8000_0000, 32'h0001_0000, 1'b0, q, lat, busy_n, stable);
        chk("minexact_q", q, 32'h8000_0000);
        chk("minexact_flags", {30'b0, div_by_zero, div_ovf}, 32'h0);

        // div_start held through busy; operands scrambled after start edge
        run_div(32'h0001_0000, 32'h0002_0000, 1'b1, q, lat, busy_n, stable);
        chk("hold_q", q, 32'h0000_8000);
        chk("hold_lat", 32'(lat), 32'(Lat));
        seen = 1'b0;
        repeat (5) begin
            @(posedge Clk);
            #1;
            if (div_valid) seen = 1'b1;
        end
        chk("hold_single", {31'b0, seen}, 32'h0);

        // Back-to-back: second start issued during the div_valid cycle
        run_div(32'h0003_0000, 32'h0002_0000, 1'b0, q, lat, busy_n, stable);
        chk("b2b_first_q", q, 32'h0001_8000);
        run_div(32'hFFFF_0000, 32'h0004_0000, 1'b0, q, lat, busy_n, stable);
        chk("b2b_second_q", q, 32'hFFFF_C000);
        chk("b2b_second_lat", 32'(lat), 32'(Lat));
        chk("b2b_stable", {31'b0, stable}, 32'h1);

        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

endmodule
